// File: rtl/aes128_word_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aes128_word_stream_ctrl
// Assembles 32-bit key/plaintext words for aes128_encrypt_top, waits out the
// core latency, then serialises the ciphertext as four output words.
// Rev    : 1.0
// ============================================================================
module aes128_word_stream_ctrl #(
  parameter int CORE_LATENCY = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_key,
  output logic [31:0] key_0,
  output logic [31:0] key_1,
  output logic [31:0] key_2,
  output logic [31:0] key_3,
  output logic [31:0] plain_text_0,
  output logic [31:0] plain_text_1,
  output logic [31:0] plain_text_2,
  output logic [31:0] plain_text_3,
  input  logic [31:0] cipher_text_0,
  input  logic [31:0] cipher_text_1,
  input  logic [31:0] cipher_text_2,
  input  logic [31:0] cipher_text_3,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [7:0] LAT_LAST = 8'(CORE_LATENCY - 1);

  state_t      r_state, w_next_state;
  logic [1:0]  r_key_cnt, r_pt_cnt, r_out_cnt;
  logic        r_key_loaded;
  logic [7:0]  r_lat_cnt;
  logic [95:0] r_cipher;  // words 2..0; word 3 goes straight to m_data
  logic        w_s_fire, w_pt_ok, w_pt_last;

  assign s_ready   = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_LOAD);
  assign w_s_fire  = s_valid & s_ready;
  assign w_pt_ok   = r_key_loaded & (r_key_cnt == 2'd0);
  assign w_pt_last = w_s_fire & ~s_key & w_pt_ok & (r_pt_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD: if (w_pt_last) w_next_state = ST_WAIT;
      ST_WAIT: if (r_lat_cnt == LAT_LAST) w_next_state = ST_OUT;
      ST_OUT:  if (m_valid && m_ready && r_out_cnt == 2'd3) w_next_state = ST_LOAD;
      default: w_next_state = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_cnt    <= 2'd0;
      r_pt_cnt     <= 2'd0;
      r_out_cnt    <= 2'd0;
      r_key_loaded <= 1'b0;
      r_lat_cnt    <= 8'd0;
      r_cipher     <= 96'd0;
      key_0        <= 32'd0;
      key_1        <= 32'd0;
      key_2        <= 32'd0;
      key_3        <= 32'd0;
      plain_text_0 <= 32'd0;
      plain_text_1 <= 32'd0;
      plain_text_2 <= 32'd0;
      plain_text_3 <= 32'd0;
      m_valid      <= 1'b0;
      m_data       <= 32'd0;
      m_last       <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_s_fire) begin
            if (s_key) begin
              // Key words are only legal between plaintext groups
              if (r_pt_cnt == 2'd0) begin
                case (r_key_cnt)
                  2'd0:    key_3 <= s_data;
                  2'd1:    key_2 <= s_data;
                  2'd2:    key_1 <= s_data;
                  default: key_0 <= s_data;
                endcase
                if (r_key_cnt == 2'd0) r_key_loaded <= 1'b0;
                if (r_key_cnt == 2'd3) r_key_loaded <= 1'b1;
                r_key_cnt <= r_key_cnt + 2'd1;
              end else begin
                err <= 1'b1;
              end
            end else if (!w_pt_ok) begin
              err <= 1'b1;
            end else begin
              case (r_pt_cnt)
                2'd0:    plain_text_3 <= s_data;
                2'd1:    plain_text_2 <= s_data;
                2'd2:    plain_text_1 <= s_data;
                default: plain_text_0 <= s_data;
              endcase
              r_pt_cnt <= r_pt_cnt + 2'd1;
              if (r_pt_cnt == 2'd3) r_lat_cnt <= 8'd0;
            end
          end
        end
        ST_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 8'd1;
          if (r_lat_cnt == LAT_LAST) begin
            r_cipher  <= {cipher_text_2, cipher_text_1, cipher_text_0};
            m_valid   <= 1'b1;
            m_data    <= cipher_text_3;
            m_last    <= 1'b0;
            r_out_cnt <= 2'd0;
          end
        end
        ST_OUT: begin
          if (m_valid && m_ready) begin
            if (r_out_cnt == 2'd3) begin
              m_valid   <= 1'b0;
              m_data    <= 32'd0;
              m_last    <= 1'b0;
              r_out_cnt <= 2'd0;
            end else begin
              r_out_cnt <= r_out_cnt + 2'd1;
              m_last    <= (r_out_cnt == 2'd2);
              case (r_out_cnt)
                2'd0:    m_data <= r_cipher[95:64];
                2'd1:    m_data <= r_cipher[63:32];
                default: m_data <= r_cipher[31:0];
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes128_word_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_aes128_word_stream_ctrl
// Directed bench with an XOR stub core standing in for aes128_encrypt_top.
// Rev    : 1.0
// ============================================================================
module tb_aes128_word_stream_ctrl;

  localparam int LAT = 3;
  localparam logic [127:0] KEY  = 128'h100F0E0D_0C0B0A09_08070605_04030201;
  localparam logic [127:0] PT1  = 128'h54494d47_206e616c_6f4e2072_6f6e6f43;
  localparam logic [127:0] PT2  = 128'h52494d47_206e616c_6f4e2072_6f6e6f43;
  localparam logic [127:0] EXP1 = 128'h4446434a_2c656b65_67492677_6b6d6d42;
  localparam logic [127:0] EXP2 = 128'h4246434a_2c656b65_67492677_6b6d6d42;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'd0;
  logic        s_key = 1'b0;
  logic [31:0] key_0, key_1, key_2, key_3;
  logic [31:0] plain_text_0, plain_text_1, plain_text_2, plain_text_3;
  logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes128_word_stream_ctrl #(.CORE_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key),
    .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .plain_text_0(plain_text_0), .plain_text_1(plain_text_1),
    .plain_text_2(plain_text_2), .plain_text_3(plain_text_3),
    .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
    .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  // Stub core: cipher = key ^ plaintext, ready within LAT cycles of stable inputs
  logic [127:0] core_s1, core_s2;
  always @(posedge clk) begin
    core_s1 <= {key_3, key_2, key_1, key_0} ^ {plain_text_3, plain_text_2, plain_text_1, plain_text_0};
    core_s2 <= core_s1;
  end
  assign {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0} = core_s2;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic k);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_key = k;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic k);
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], k);
  endtask

  // Gathers up to four output words; only records, comparisons stay in the tests
  task automatic collect(input logic [15:0] pat, output logic [127:0] words,
                         output logic [3:0] lasts, output int nhs,
                         output int wait_cyc, output logic held_ok);
    logic [31:0] prev;
    logic        stalled;
    int          i;
    words = '0; lasts = '0; nhs = 0; wait_cyc = 0; held_ok = 1'b1;
    stalled = 1'b0; prev = '0; i = 0;
    while (!m_valid && wait_cyc < 40) begin @(negedge clk); wait_cyc++; end
    while (m_valid && nhs < 4 && i < 60) begin
      m_ready = (i < 16) ? pat[i] : 1'b1;
      if (stalled && m_data !== prev) held_ok = 1'b0;
      if (m_ready) begin
        words[127-32*nhs -: 32] = m_data;
        lasts[3-nhs] = m_last;
        nhs++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = m_data;
      end
      i++;
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b1; s_key = 1'b1; s_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    checks++; if ({m_valid, m_last, busy, err} !== 4'b0000) begin failures++;
      $display("FAIL reset_flags: {m_valid,m_last,busy,err}=%b required 0000", {m_valid, m_last, busy, err}); end
    checks++; if (m_data !== 32'd0) begin failures++;
      $display("FAIL reset_m_data: got %h required 00000000", m_data); end
    checks++; if ({key_3, key_2, key_1, key_0} !== 128'd0) begin failures++;
      $display("FAIL reset_key: got %h required 0", {key_3, key_2, key_1, key_0}); end
    checks++; if ({plain_text_3, plain_text_2, plain_text_1, plain_text_0} !== 128'd0) begin failures++;
      $display("FAIL reset_pt: got %h required 0", {plain_text_3, plain_text_2, plain_text_1, plain_text_0}); end
    reset = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin failures++;
      $display("FAIL reset_release_s_ready: got %b required 1", s_ready); end
  endtask

  task automatic test_single_block();
    logic [127:0] w; logic [3:0] l; int n, wc; logic h;
    m_ready = 1'b1;
    send_block(KEY, 1'b1);
    send_block(PT1, 1'b0);
    checks++; if (key_3 !== 32'h100F0E0D || key_0 !== 32'h04030201) begin failures++;
      $display("FAIL blk_key: key_3=%h key_0=%h required 100f0e0d 04030201", key_3, key_0); end
    checks++; if (plain_text_0 !== 32'h6f6e6f43 || plain_text_3 !== 32'h54494d47) begin failures++;
      $display("FAIL blk_pt: pt_0=%h pt_3=%h required 6f6e6f43 54494d47", plain_text_0, plain_text_3); end
    checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL blk_wait_state: s_ready=%b busy=%b required 0 1", s_ready, busy); end
    collect(16'hFFFF, w, l, n, wc, h);
    checks++; if (wc !== LAT) begin failures++;
      $display("FAIL blk_latency: m_valid after %0d cycles required %0d", wc, LAT); end
    checks++; if (w !== EXP1) begin failures++;
      $display("FAIL blk_words: got %h required %h", w, EXP1); end
    checks++; if (l !== 4'b0001 || n !== 4) begin failures++;
      $display("FAIL blk_last: lasts=%b handshakes=%0d required 0001 4", l, n); end
    checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || err !== 1'b0) begin failures++;
      $display("FAIL blk_return: s_ready=%b m_valid=%b err=%b required 1 0 0", s_ready, m_valid, err); end
  endtask

  task automatic test_backpressure();
    logic [127:0] w; logic [3:0] l; int n, wc; logic h;
    send_block(KEY, 1'b1);
    send_block(PT1, 1'b0);
    collect(16'hFFE9, w, l, n, wc, h);
    checks++; if (h !== 1'b1) begin failures++;
      $display("FAIL bp_hold: m_data changed while stalled (held=%b required 1)", h); end
    checks++; if (w !== EXP1 || l !== 4'b0001) begin failures++;
      $display("FAIL bp_words: got %h lasts=%b required %h 0001", w, l, EXP1); end
    repeat (3) @(negedge clk);
    checks++; if (n !== 4 || m_valid !== 1'b0) begin failures++;
      $display("FAIL bp_count: handshakes=%0d m_valid=%b required 4 0", n, m_valid); end
  endtask

  task automatic test_key_retained();
    logic [127:0] w; logic [3:0] l; int n, wc; logic h;
    send_block(PT2, 1'b0);
    collect(16'hFFFF, w, l, n, wc, h);
    checks++; if (w[127:96] !== 32'h4246434a) begin failures++;
      $display("FAIL retain_first: got %h required 4246434a", w[127:96]); end
    checks++; if (w !== EXP2 || n !== 4) begin failures++;
      $display("FAIL retain_words: got %h n=%0d required %h 4", w, n, EXP2); end
  endtask

  task automatic test_pt_before_key();
    apply_reset();
    send_word(32'hCAFEF00D, 1'b0);
    checks++; if (err !== 1'b1) begin failures++;
      $display("FAIL nokey_err: got %b required 1", err); end
    checks++; if (plain_text_3 !== 32'd0 || busy !== 1'b0 || s_ready !== 1'b1) begin failures++;
      $display("FAIL nokey_ignored: pt_3=%h busy=%b s_ready=%b required 0 0 1", plain_text_3, busy, s_ready); end
  endtask

  task automatic test_key_mid_block();
    logic [127:0] w; logic [3:0] l; int n, wc; logic h;
    apply_reset();
    send_block(KEY, 1'b1);
    send_word(PT1[127:96], 1'b0);
    send_word(PT1[95:64], 1'b0);
    checks++; if (err !== 1'b0) begin failures++;
      $display("FAIL mid_err_pre: got %b required 0", err); end
    send_word(32'hFFFFFFFF, 1'b1);
    checks++; if (err !== 1'b1 || {key_3, key_2, key_1, key_0} !== KEY) begin failures++;
      $display("FAIL mid_key_drop: err=%b key=%h required 1 %h", err, {key_3, key_2, key_1, key_0}, KEY); end
    send_word(PT1[63:32], 1'b0);
    send_word(PT1[31:0], 1'b0);
    collect(16'hFFFF, w, l, n, wc, h);
    checks++; if (w !== EXP1 || n !== 4 || wc !== LAT) begin failures++;
      $display("FAIL mid_block: got %h n=%0d lat=%0d required %h 4 %0d", w, n, wc, EXP1, LAT); end
    checks++; if (err !== 1'b1) begin failures++;
      $display("FAIL mid_err_sticky: got %b required 1", err); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_key_retained();
    test_pt_before_key();
    test_key_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
